led_sched: RTL

Round-robin scheduler that shares the board's two active-low status LEDs (red, green) between four requesters. Each requester presents a 4-step LED sequence. The block grants the LEDs to one requester at a time, plays that sequence at a fixed step rate derived from the 12 MHz clock, and signals completion. It sits between the status sources (heartbeat, UART activity, error flags) and the LED pins.

---
 rtl/led_sched_if.sv | 22 ++
 rtl/led_sched.sv | 136 +++++++++++++
 2 files changed

// File: rtl/led_sched_if.sv
// Bundle of request-side and LED-side signals for led_sched.
// Latency: n/a (wires only); backpressure: none, requests are level-held.
// master = requester side (drives req/req_seq), slave = scheduler side.
interface led_sched_if;
  logic [3:0]  req;        // level request per requester
  logic [31:0] req_seq;    // 4 x 8-bit LED sequences, requester i at [8i+7:8i]
  logic [3:0]  grant;      // one-hot current owner, 0 when idle
  logic [3:0]  done;       // one-cycle completion pulse per requester
  logic        busy;       // high while a sequence plays
  logic        LED_RED;    // active-low red LED
  logic        LED_GREEN;  // active-low green LED

  modport master (
    output req, req_seq,
    input  grant, done, busy, LED_RED, LED_GREEN
  );

  modport slave (
    input  req, req_seq,
    output grant, done, busy, LED_RED, LED_GREEN
  );
endinterface

// File: rtl/led_sched.sv
// Round-robin scheduler sharing two active-low status LEDs between four requesters.
// Latency: req sampled at edge N -> grant/busy/step-0 LEDs after edge N; a sequence lasts 4*TICK_DIV cycles.
// Backpressure: none; req is a level, a granted sequence always runs to completion (or preemption/reset).
//
// Ports: CLK (single clock), RST (synchronous, active-high), bus (led_sched_if.slave):
//   req/req_seq in, grant/done/busy/LED_RED/LED_GREEN out.
// Optional feature: define LED_SCHED_PREEMPT_EN to make requester 3 preempt any other owner.
module led_sched #(
  parameter int TICK_DIV = 6_000_000  // clock cycles per sequence step, >= 2
) (
  input  logic        CLK,
  input  logic        RST,
  led_sched_if.slave  bus
);

  localparam int             TW       = $clog2(TICK_DIV);
  localparam logic [TW-1:0]  TICK_MAX = TW'(TICK_DIV - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state, state_nxt;
  logic [1:0]     step;
  logic [TW-1:0]  tick;
  logic [7:0]     seq;       // sequence latched at grant time
  logic [1:0]     last;      // most recently completed owner
  logic [1:0]     owner;     // index of current owner, meaningful only in RUN
  logic [3:0]     done_r;

  logic           any_req;
  logic           seq_end;
  logic           preempt;
  logic [1:0]     pick_idle;
  logic [1:0]     pick_cmp;
  logic [1:0]     cur_bits;

  // First requester found scanning base+1, base+2, base+3, base.
  function automatic logic [1:0] rr_pick(input logic [1:0] base, input logic [3:0] r);
    logic [1:0] idx;
    logic       found;
    rr_pick = base;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = base + 2'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign any_req   = |bus.req;
  assign seq_end   = (state == RUN) && (step == 2'd3) && (tick == TICK_MAX);
  assign pick_idle = rr_pick(last, bus.req);
  // At completion the search starts after the finishing owner, i.e. the updated last.
  assign pick_cmp  = rr_pick(owner, bus.req);

`ifdef LED_SCHED_PREEMPT_EN
  assign preempt = (state == RUN) && bus.req[3] && (owner != 2'd3);
`else
  assign preempt = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (any_req) state_nxt = RUN;
      RUN:  if (!preempt && seq_end && !any_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: owner selection, sequence latch, step/tick counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      step   <= 2'd0;
      tick   <= '0;
      seq    <= 8'd0;
      last   <= 2'd3;
      owner  <= 2'd0;
      done_r <= 4'd0;
    end else begin
      done_r <= 4'd0;
      if (state == IDLE) begin
        if (any_req) begin
          owner <= pick_idle;
          seq   <= bus.req_seq[{pick_idle, 3'b000} +: 8];
          step  <= 2'd0;
          tick  <= '0;
        end
      end else if (preempt) begin
        // Aborted owner gets no done and last is left alone.
        owner <= 2'd3;
        seq   <= bus.req_seq[31:24];
        step  <= 2'd0;
        tick  <= '0;
      end else if (tick == TICK_MAX) begin
        tick <= '0;
        step <= step + 2'd1;  // wraps 3 -> 0, ready for a back-to-back grant
        if (step == 2'd3) begin
          done_r <= 4'b0001 << owner;
          last   <= owner;
          if (any_req) begin
            owner <= pick_cmp;
            seq   <= bus.req_seq[{pick_cmp, 3'b000} +: 8];
          end
        end
      end else begin
        tick <= tick + 1'b1;
      end
    end
  end

  // Outputs: decoded from registers only, no combinational path from inputs
  always_comb begin
    cur_bits      = seq[{step, 1'b0} +: 2];
    bus.grant     = 4'd0;
    bus.busy      = 1'b0;
    bus.LED_RED   = 1'b1;
    bus.LED_GREEN = 1'b1;
    bus.done      = done_r;
    if (state == RUN) begin
      bus.grant     = 4'b0001 << owner;
      bus.busy      = 1'b1;
      bus.LED_RED   = ~cur_bits[0];
      bus.LED_GREEN = ~cur_bits[1];
    end
  end

endmodule
